subleq_control: RTL
===================

Name: subleq_control

Overview:
- Main control FSM for the SUBLEQ URISC core; sequences PC, operand-address registers (A, B, C), operand-data registers (OPA, OPB) and the memory port.
- Executes one instruction as fetch a,b,c → read mem[a], mem[b] → write mem[b]-mem[a] → branch to c if result <= 0.
- Drives only load/inc strobes and selects; all data stays in the datapath registers.

Parameters:
- MEM_TIMEOUT, 0, max cycles a memory request may wait for mem_ready; 0 disables the timeout.
- TO_W, 8, timeout counter width; MEM_TIMEOUT must be < 2^TO_W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin execution
- mem_ready  in  1  memory completes the current request this cycle
- res_le_zero  in  1  datapath flag: (OPB - OPA) <= 0, signed, valid while in WRITE_B
- c_is_halt  in  1  datapath flag: C register == all ones
- mem_req  out  1  memory request active
- mem_we  out  1  1 = write (OPB-OPA to mem[B]), 0 = read
- addr_sel  out  2  memory address source: 0=PC, 1=A, 2=B
- pc_inc, pc_load  out  1 each  PC increment / load from C
- a_load, b_load, c_load  out  1 each  latch read data into A/B/C
- opa_load, opb_load  out  1 each  latch read data into OPA/OPB
- retire  out  1  one-cycle pulse per completed instruction
- busy, halted, fault  out  1 each  status
- state  out  4  current state encoding (debug)

Behaviour:
- States/encodings: IDLE=0, FETCH_A=1, FETCH_B=2, FETCH_C=3, READ_A=4, READ_B=5, WRITE_B=6, BRANCH=7, HALT=8, FAULT=9.
- Reset: state=IDLE; all strobes, mem_req, mem_we, retire, busy, halted, fault = 0; addr_sel=0; le_flag and timeout counter cleared. Reset mid-instruction aborts immediately; no strobe issued.
- IDLE: waits for start; start=1 → FETCH_A next cycle.
- Memory states hold mem_req=1 with stable addr_sel/mem_we every cycle until mem_ready. Register strobes are combinational, asserted only in the cycle mem_ready=1.
- FETCH_A/B/C: addr_sel=0; on ready pulse a_load/b_load/c_load together with pc_inc; advance to next state. After FETCH_C, PC = old PC + 3.
- READ_A: addr_sel=1; on ready opa_load → READ_B. READ_B: addr_sel=2; on ready opb_load → WRITE_B.
- WRITE_B: addr_sel=2, mem_we=1; on ready latch le_flag <= res_le_zero → BRANCH.
- BRANCH (1 cycle, mem_req=0): retire=1. If le_flag and c_is_halt → HALT, no pc_load. Else if le_flag → pc_load=1, FETCH_A. Else → FETCH_A (PC already +3).
- HALT: halted=1, sticky until reset; start ignored.
- busy=1 in states 1–7.
- Timeout (MEM_TIMEOUT>0): counter clears on entry to each memory state, increments each waiting cycle; reaching MEM_TIMEOUT with no mem_ready → FAULT. FAULT: fault=1, mem_req=0, sticky until reset. mem_ready on the same cycle the count hits the limit wins (normal completion).
- mem_ready outside memory states is ignored. Exactly one strobe set per completed access; pc_inc and pc_load never assert together.
- Instruction latency with zero-wait memory (mem_ready tied high): 7 cycles, FETCH_A through BRANCH.

Optional Feature:
- Macro SUBLEQ_STEP_EN. When defined, adds input port step (1 bit). BRANCH goes to a PAUSE state (encoding 10, busy=0) instead of FETCH_A. PAUSE advances to FETCH_A on step=1. HALT and FAULT paths are unchanged. IDLE+start runs only the first instruction.
- Without the macro: no step port, no PAUSE state; execution is free-running.

Test Plan:
- mem_ready=1, res_le_zero=0, start pulse at cycle 2 → states 1..7 in order, three pc_inc pulses, retire at BRANCH, no pc_load; second instruction begins at FETCH_A on cycle 10.
- res_le_zero=1, c_is_halt=0 → pc_load=1 exactly once in BRANCH, with pc_inc=0.
- res_le_zero=1, c_is_halt=1 → retire=1, then HALT with halted=1 held for 20 cycles; start pulses ignored; mem_req stays 0.
- mem_ready delayed 3 cycles in READ_B → mem_req and addr_sel=2 held 4 cycles; opb_load asserts only in the ready cycle.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH_B → FAULT after 4 wait cycles, fault=1, mem_req=0; then reset → IDLE with all outputs 0.
- Reset asserted during WRITE_B → state=0 asynchronously; no retire, no pc_load. With SUBLEQ_STEP_EN, execution stays in PAUSE until a step pulse, then enters FETCH_A on the next cycle.

Source files
------------

// File: rtl/subleq_control.sv
// Main sequencing FSM of the SUBLEQ URISC core: fetch a,b,c, read operands, write back, branch.
// Defining SUBLEQ_STEP_EN adds a step input and a PAUSE state after every retired instruction.
module subleq_control #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mem_ready,
    input  logic       res_le_zero,
    input  logic       c_is_halt,
`ifdef SUBLEQ_STEP_EN
    input  logic       step,
`endif
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] addr_sel,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       a_load,
    output logic       b_load,
    output logic       c_load,
    output logic       opa_load,
    output logic       opb_load,
    output logic       retire,
    output logic       busy,
    output logic       halted,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH_A = 4'd1,
        S_FETCH_B = 4'd2,
        S_FETCH_C = 4'd3,
        S_READ_A  = 4'd4,
        S_READ_B  = 4'd5,
        S_WRITE_B = 4'd6,
        S_BRANCH  = 4'd7,
        S_HALT    = 4'd8,
        S_FAULT   = 4'd9
`ifdef SUBLEQ_STEP_EN
        , S_PAUSE = 4'd10
`endif
    } state_t;

`ifdef SUBLEQ_STEP_EN
    localparam state_t S_AFTER_BRANCH = S_PAUSE;
`else
    localparam state_t S_AFTER_BRANCH = S_FETCH_A;
`endif

    state_t            state_q, state_d;
    logic              le_q, le_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              in_mem_s;
    logic              timeout_s;

    // Moore outputs packed as {mem_req, mem_we, addr_sel, retire, busy, halted, fault}
    function automatic logic [7:0] moore_out(input state_t s);
        case (s)
            S_FETCH_A, S_FETCH_B, S_FETCH_C: moore_out = 8'b1000_0100;
            S_READ_A:  moore_out = 8'b1001_0100;
            S_READ_B:  moore_out = 8'b1010_0100;
            S_WRITE_B: moore_out = 8'b1110_0100;
            S_BRANCH:  moore_out = 8'b0000_1100;
            S_HALT:    moore_out = 8'b0000_0010;
            S_FAULT:   moore_out = 8'b0000_0001;
            default:   moore_out = 8'b0000_0000;
        endcase
    endfunction

    assign in_mem_s  = state_q inside {S_FETCH_A, S_FETCH_B, S_FETCH_C,
                                       S_READ_A, S_READ_B, S_WRITE_B};
    // Limit is checked before incrementing, so mem_ready in the limit cycle still completes.
    assign timeout_s = (MEM_TIMEOUT != 0) && (to_q == TO_W'(MEM_TIMEOUT - 1));

    // Next-state decode and combinational register strobes (only in the ready cycle)
    always_comb begin
        state_d  = state_q;
        le_d     = le_q;
        to_d     = '0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        a_load   = 1'b0;
        b_load   = 1'b0;
        c_load   = 1'b0;
        opa_load = 1'b0;
        opb_load = 1'b0;
        if (in_mem_s && !mem_ready) begin
            if (timeout_s) begin
                state_d = S_FAULT;
            end else begin
                state_d = state_q;
                to_d    = (MEM_TIMEOUT != 0) ? to_q + TO_W'(1) : '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_FETCH_A;
                    else       state_d = S_IDLE;
                end
                S_FETCH_A: begin
                    pc_inc  = 1'b1;
                    a_load  = 1'b1;
                    state_d = S_FETCH_B;
                end
                S_FETCH_B: begin
                    pc_inc  = 1'b1;
                    b_load  = 1'b1;
                    state_d = S_FETCH_C;
                end
                S_FETCH_C: begin
                    pc_inc  = 1'b1;
                    c_load  = 1'b1;
                    state_d = S_READ_A;
                end
                S_READ_A: begin
                    opa_load = 1'b1;
                    state_d  = S_READ_B;
                end
                S_READ_B: begin
                    opb_load = 1'b1;
                    state_d  = S_WRITE_B;
                end
                S_WRITE_B: begin
                    le_d    = res_le_zero;
                    state_d = S_BRANCH;
                end
                S_BRANCH: begin
                    if (le_q && c_is_halt) begin
                        state_d = S_HALT;
                    end else if (le_q) begin
                        pc_load = 1'b1;
                        state_d = S_AFTER_BRANCH;
                    end else begin
                        state_d = S_AFTER_BRANCH;
                    end
                end
`ifdef SUBLEQ_STEP_EN
                S_PAUSE: begin
                    if (step) state_d = S_FETCH_A;
                    else      state_d = S_PAUSE;
                end
`endif
                S_HALT:  state_d = S_HALT;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FAULT;
            endcase
        end
    end

    // State, branch flag, wait counter and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            le_q    <= 1'b0;
            to_q    <= '0;
            {mem_req, mem_we, addr_sel, retire, busy, halted, fault} <= 8'b0000_0000;
            state   <= 4'd0;
        end else begin
            state_q <= state_d;
            le_q    <= le_d;
            to_q    <= to_d;
            {mem_req, mem_we, addr_sel, retire, busy, halted, fault} <= moore_out(state_d);
            state   <= state_d;
        end
    end

endmodule
